// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: seeds the LFSR, raises one mole per round, scores hits and timeouts.
// Optional build macro MOLE_NO_REPEAT_EN: never raise the same hole twice in a row.
module mole_scheduler #(
    parameter int unsigned UP_CYCLES  = 50000000,
    parameter int unsigned GAP_CYCLES = 12500000,
    parameter int unsigned ROUNDS     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] hit,
    input  logic [3:0] rndnum,
    output logic       lfsr_load,
    output logic [8:0] mole,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_PICK = 3'd2;
    localparam logic [2:0] S_UP   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    round_cnt, round_cnt_n;
    logic [8:0]    mole_n;
    logic [7:0]    score_n, misses_n;
    logic          lfsr_load_n, busy_n, done_n;
    logic          pick_ok;
    logic          game_start;

    assign game_start = ((state == S_IDLE) || (state == S_DONE)) && start;

`ifdef MOLE_NO_REPEAT_EN
    logic [3:0] prev_hole;

    // Last raised hole; 4'hF means no hole raised yet this game
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_hole <= 4'hF;
        end else if (game_start) begin
            prev_hole <= 4'hF;
        end else if ((state == S_PICK) && pick_ok) begin
            prev_hole <= rndnum;
        end
    end

    assign pick_ok = (rndnum <= 4'd8) && (rndnum != prev_hole);
`else
    assign pick_ok = (rndnum <= 4'd8);
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            round_cnt <= '0;
            mole      <= '0;
            score     <= '0;
            misses    <= '0;
            lfsr_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            round_cnt <= round_cnt_n;
            mole      <= mole_n;
            score     <= score_n;
            misses    <= misses_n;
            lfsr_load <= lfsr_load_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        round_cnt_n = round_cnt;
        mole_n      = mole;
        score_n     = score;
        misses_n    = misses;

        case (state)
            S_IDLE, S_DONE: begin
                if (game_start) begin
                    score_n     = '0;
                    misses_n    = '0;
                    round_cnt_n = '0;
                    state_n     = S_SEED;
                end
            end
            S_SEED: state_n = S_PICK;
            S_PICK: begin
                if (pick_ok) begin
                    mole_n  = 9'(1) << rndnum;
                    timer_n = TW'(UP_CYCLES - 1);
                    state_n = S_UP;
                end
            end
            S_UP: begin
                // A hit on the raised hole takes priority over the timeout
                if ((hit & mole) != '0) begin
                    score_n     = (score == 8'hFF) ? score : score + 8'd1;
                    mole_n      = '0;
                    round_cnt_n = round_cnt + 8'd1;
                    timer_n     = TW'(GAP_CYCLES - 1);
                    state_n     = S_GAP;
                end else if (timer == '0) begin
                    misses_n    = (misses == 8'hFF) ? misses : misses + 8'd1;
                    mole_n      = '0;
                    round_cnt_n = round_cnt + 8'd1;
                    timer_n     = TW'(GAP_CYCLES - 1);
                    state_n     = S_GAP;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_n = (round_cnt == 8'(ROUNDS)) ? S_DONE : S_PICK;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        lfsr_load_n = (state_n == S_SEED);
        busy_n      = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n      = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed game plus randomized games against a round-level model.
module tb_mole_scheduler;

    localparam int UP  = 4;
    localparam int GAP = 2;
    localparam int RND = 3;
`ifdef MOLE_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] hit;
    logic [3:0] rndnum;
    logic       lfsr_load;
    logic [8:0] mole;
    logic [7:0] score;
    logic [7:0] misses;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Game-level reference model
    int exp_score, exp_misses, exp_round, prev;
    int cand_q[$];

    mole_scheduler #(.UP_CYCLES(UP), .GAP_CYCLES(GAP), .ROUNDS(RND)) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit), .rndnum(rndnum),
        .lfsr_load(lfsr_load), .mole(mole), .score(score), .misses(misses),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; hit = '0; rndnum = '0;
        step();
        step();
        checks++;
        if ({mole, score, misses, lfsr_load, busy, done} !== 29'd0) begin
            errors++;
            $display("FAIL reset_values got mole=%h score=%0d misses=%0d load=%b busy=%b done=%b exp all zero",
                     mole, score, misses, lfsr_load, busy, done);
        end
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy, done, lfsr_load, mole} !== 12'd0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b done=%b load=%b mole=%h exp 0", busy, done, lfsr_load, mole);
        end
    endtask

    task automatic start_game();
        exp_score = 0; exp_misses = 0; exp_round = 0; prev = 15;
        start = 1'b1;
        step();
        checks++;
        if (lfsr_load !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || score !== 8'd0 || misses !== 8'd0) begin
            errors++;
            $display("FAIL seed_cycle got load=%b busy=%b done=%b score=%0d misses=%0d exp 1 1 0 0 0",
                     lfsr_load, busy, done, score, misses);
        end
        start = 1'b0;
        step();
        checks++;
        if (lfsr_load !== 1'b0 || busy !== 1'b1 || mole !== 9'd0) begin
            errors++;
            $display("FAIL load_pulse got load=%b busy=%b mole=%h exp 0 1 000", lfsr_load, busy, mole);
        end
    endtask

    // One round: candidates from cand_q (random fallback), hit on visible cycle hit_at (0 = never)
    task automatic play_round(input int hit_at, input logic [8:0] noise, input logic [8:0] extra);
        int v;
        int r;
        logic [8:0] m;
        v = -1;
        for (int n = 0; n < 64 && v < 0; n++) begin
            r = (cand_q.size() != 0) ? cand_q.pop_front() : int'($urandom_range(0, 8));
            rndnum = 4'(r);
            start = 1'($urandom_range(0, 1));
            step();
            if (r <= 8 && !(NOREP && r == prev)) begin
                v = r;
            end else begin
                checks++;
                if (mole !== 9'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL pick_hold rnd=%0d got mole=%h busy=%b exp 000 1", r, mole, busy);
                end
            end
        end
        cand_q.delete();
        if (v < 0) begin
            errors++; checks++;
            $display("FAIL pick_budget got no accept exp accept within 64 cycles");
            return;
        end
        prev = v;
        m = 9'd1 << v;
        for (int k = 1; k <= UP; k++) begin
            checks++;
            if (mole !== m || busy !== 1'b1) begin
                errors++;
                $display("FAIL mole_up k=%0d got mole=%h busy=%b exp %h 1", k, mole, busy, m);
            end
            hit = (k == hit_at) ? (extra | m) : (noise & ~m);
            start = 1'($urandom_range(0, 1));
            step();
            hit = '0;
            if (k == hit_at) begin
                exp_score = (exp_score < 255) ? exp_score + 1 : 255;
                break;
            end
            if (k == UP) exp_misses = (exp_misses < 255) ? exp_misses + 1 : 255;
        end
        exp_round++;
        checks++;
        if (mole !== 9'd0 || score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
            errors++;
            $display("FAIL round_end got mole=%h score=%0d misses=%0d exp 000 %0d %0d",
                     mole, score, misses, exp_score, exp_misses);
        end
        for (int g = 1; g <= GAP; g++) begin
            checks++;
            if (mole !== 9'd0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL gap g=%0d got mole=%h busy=%b done=%b exp 000 1 0", g, mole, busy, done);
            end
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        checks++;
        if (exp_round == RND) begin
            if (done !== 1'b1 || busy !== 1'b0 || score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
                errors++;
                $display("FAIL game_done got done=%b busy=%b score=%0d misses=%0d exp 1 0 %0d %0d",
                         done, busy, score, misses, exp_score, exp_misses);
            end
        end else if (done !== 1'b0 || busy !== 1'b1 || mole !== 9'd0) begin
            errors++;
            $display("FAIL next_pick got done=%b busy=%b mole=%h exp 0 1 000", done, busy, mole);
        end
    endtask

    task automatic test_directed_game();
        start_game();
        cand_q = '{9, 12, 5};
        play_round(0, 9'd0, 9'd0);
        cand_q = '{2};
        play_round(2, 9'h001, 9'd0);
        cand_q = '{2, 7};
        play_round(UP, 9'd0, 9'd0);
    endtask

    task automatic test_done_hold();
        repeat (5) step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || score !== 8'(exp_score) || misses !== 8'(exp_misses) || mole !== 9'd0) begin
            errors++;
            $display("FAIL done_hold got done=%b busy=%b score=%0d misses=%0d exp 1 0 %0d %0d",
                     done, busy, score, misses, exp_score, exp_misses);
        end
    endtask

    task automatic test_random_games();
        for (int gm = 0; gm < 6; gm++) begin
            start_game();
            while (exp_round < RND) begin
                for (int j = $urandom_range(0, 3); j > 0; j--) cand_q.push_back(int'($urandom_range(9, 15)));
                if (prev <= 8 && $urandom_range(0, 1) == 1) cand_q.push_back(prev);
                play_round(int'($urandom_range(0, UP)), 9'($urandom), 9'($urandom));
            end
            test_done_hold();
        end
    endtask

    task automatic test_reset_mid_up();
        start_game();
        cand_q = '{6};
        play_round(1, 9'd0, 9'd0);
        rndnum = 4'd3;
        step();
        checks++;
        if (mole !== 9'h008 || score !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset_up got mole=%h score=%0d exp 008 1", mole, score);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mole, score, misses, lfsr_load, busy, done} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset got mole=%h score=%0d misses=%0d load=%b busy=%b done=%b exp all zero",
                     mole, score, misses, lfsr_load, busy, done);
        end
        step();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({mole, busy, done, lfsr_load} !== 12'd0) begin
            errors++;
            $display("FAIL post_reset_idle got mole=%h busy=%b done=%b load=%b exp 0", mole, busy, done, lfsr_load);
        end
    endtask

    initial begin
        test_reset();
        test_directed_game();
        test_done_hold();
        test_random_games();
        test_reset_mid_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
